// File: rtl/data_mem_pipe.sv
// data_mem_pipe: parametrised data memory with a valid/ready request port, fixed-latency
// pipelined load responses and an optional zeroing sweep after reset.
module data_mem_pipe #(
  parameter int DW             = 8,
  parameter int AW             = 8,
  parameter int RL             = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam state_t      RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;
  localparam logic [AW:0] LAST_ADDR   = {1'b0, {AW{1'b1}}};

  state_t        state;
  state_t        state_next;
  logic [AW:0]   cnt;
  logic [DW-1:0] mem [2**AW];
  logic [RL-1:0] pipe_valid;
  logic [DW-1:0] pipe_data [RL];
  logic          load_accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // NOTE: every output of this block gets a default before the case, so no path leaves
  // a variable unassigned and no latch can be inferred.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = req_addr;
    mem_wdata  = req_wdata;
    case (state)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = !reset;
        mem_waddr = cnt[AW-1:0];
        mem_wdata = '0;
        if (cnt == LAST_ADDR) state_next = READY;
      end
      READY: begin
        req_ready = !reset;
        mem_we    = req_valid && req_ready && req_write;
      end
    endcase
  end

  assign load_accept = req_valid && req_ready && !req_write;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + (AW+1)'(1);
    end
  end

  // NOTE: the array has no reset; zeroing is the sweep's job, which keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // The read samples the array before this edge's store lands, giving old-data on a
  // load followed by a store, while an earlier store is already visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < RL; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= load_accept;
      if (load_accept) pipe_data[0] <= mem[req_addr];
      for (int i = 1; i < RL; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Data stages only advance with a valid word, so the last stage holds between pulses.
  assign rsp_valid = pipe_valid[RL-1];
  assign rsp_rdata = pipe_data[RL-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: drives three instances (RL=1,2,3) with shared stimulus plus one
// instance without the clear sweep, and checks them against a queue-based memory model.
module tb_data_mem_pipe;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    int            rl;
    int            en;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;

  logic          rdy  [1:3];
  logic          vld  [1:3];
  logic [DW-1:0] rdat [1:3];
  logic          bsy  [1:3];

  logic          nc_ready, nc_valid, nc_busy;
  logic [DW-1:0] nc_rdata;

  data_mem_pipe #(.DW(DW), .AW(AW), .RL(1), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_rdata(rdat[1]), .busy(bsy[1]));

  data_mem_pipe #(.DW(DW), .AW(AW), .RL(2), .CLEAR_ON_RESET(1'b1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_rdata(rdat[2]), .busy(bsy[2]));

  data_mem_pipe #(.DW(DW), .AW(AW), .RL(3), .CLEAR_ON_RESET(1'b1)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[3]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[3]), .rsp_rdata(rdat[3]), .busy(bsy[3]));

  data_mem_pipe #(.DW(DW), .AW(AW), .RL(1), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .req_valid(1'b0), .req_ready(nc_ready),
    .req_write(1'b0), .req_addr('0), .req_wdata('0),
    .rsp_valid(nc_valid), .rsp_rdata(nc_rdata), .busy(nc_busy));

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            edge_cnt = 0;
  int            hold_err = 0;
  int            nc_pulses = 0;
  logic [DW-1:0] last_data [1:3];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            model_ready = 1'b0;
  rsp_t          exp_q [$];
  rsp_t          obs_q [$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record each response with the edge it follows; also watch rsp_rdata hold behaviour.
  always @(negedge clk) begin
    for (int r = 1; r <= 3; r++) begin
      if (reset) begin
        last_data[r] <= '0;
      end else if (vld[r] === 1'b1) begin
        obs_q.push_back('{rl: r, en: edge_cnt, data: rdat[r]});
        last_data[r] <= rdat[r];
      end else if (rdat[r] !== last_data[r]) begin
        hold_err <= hold_err + 1;
      end
    end
    if (nc_valid === 1'b1) nc_pulses <= nc_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: flat array memory plus expected (latency, edge, data) tuples.
  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
  endtask

  task automatic drive(input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    if (v && model_ready) begin
      if (w) ref_mem[a] = d;
      else for (int r = 1; r <= 3; r++) exp_q.push_back('{rl: r, en: edge_cnt + r, data: ref_mem[a]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
  endtask

  function automatic int count_unmatched();
    int n;
    bit hit;
    n = 0;
    foreach (exp_q[i]) begin
      hit = 1'b0;
      foreach (obs_q[j]) if (obs_q[j] == exp_q[i]) hit = 1'b1;
      if (!hit) n++;
    end
    if (obs_q.size() > exp_q.size()) n += obs_q.size() - exp_q.size();
    return n;
  endfunction

  function automatic int count_rl(input int rl);
    int n;
    n = 0;
    foreach (obs_q[j]) if (obs_q[j].rl == rl) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] nth_data(input int rl, input int k);
    int n;
    logic [DW-1:0] d;
    n = 0;
    d = 'x;
    foreach (obs_q[j]) if (obs_q[j].rl == rl) begin
      if (n == k) d = obs_q[j].data;
      n++;
    end
    return d;
  endfunction

  function automatic int nth_edge(input int rl, input int k);
    int n;
    int e;
    n = 0;
    e = -1;
    foreach (obs_q[j]) if (obs_q[j].rl == rl) begin
      if (n == k) e = obs_q[j].en;
      n++;
    end
    return e;
  endfunction

  // Counts edges from reset release until busy drops; req_ready must stay low meanwhile.
  task automatic wait_sweep();
    int  n;
    int  ready_bad;
    bit  done;
    n = 0;
    ready_bad = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bsy[1] !== 1'b1) done = 1'b1;
      else for (int r = 1; r <= 3; r++) if (rdy[r] !== 1'b0) ready_bad++;
    end
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL sweep_length: busy fell after %0d edges, expected %0d", n, DEPTH);
    end
    checks++;
    if (ready_bad !== 0) begin
      errors++;
      $display("FAIL ready_during_clear: %0d high samples, expected 0", ready_bad);
    end
    for (int r = 1; r <= 3; r++) begin
      checks++;
      if (rdy[r] !== 1'b1 || bsy[r] !== 1'b0) begin
        errors++;
        $display("FAIL ready_after_sweep rl=%0d: ready=%b busy=%b, expected 1/0", r, rdy[r], bsy[r]);
      end
    end
    model_ready = 1'b1;
  endtask

  task automatic check_in_reset();
    for (int r = 1; r <= 3; r++) begin
      checks++;
      if ({vld[r], rdat[r], rdy[r], bsy[r]} !== {1'b0, {DW{1'b0}}, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL in_reset rl=%0d: valid=%b rdata=%h ready=%b busy=%b, expected 0/0000/0/1",
                 r, vld[r], rdat[r], rdy[r], bsy[r]);
      end
    end
    checks++;
    if ({nc_ready, nc_busy} !== 2'b00) begin
      errors++;
      $display("FAIL in_reset_noclear: ready=%b busy=%b, expected 0/0", nc_ready, nc_busy);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; responses not yet seen are discarded.
  task automatic apply_reset();
    rsp_t keep [$];
    @(posedge clk);
    #3;
    reset = 1'b1;
    req_valid = 1'b0;
    model_ready = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].en < edge_cnt) keep.push_back(exp_q[i]);
    exp_q = keep;
    #1;
    check_in_reset();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_in_reset();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({nc_ready, nc_busy} !== 2'b10) begin
      errors++;
      $display("FAIL noclear_ready: ready=%b busy=%b, expected 1/0", nc_ready, nc_busy);
    end
    wait_sweep();
    idle(1);
  endtask

  task automatic test_sweep();
    clear_queues();
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b1, AW'(a), DW'($urandom));
    apply_reset();
    wait_sweep();
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, AW'(a), '0);
    idle(5);
    checks++;
    if (count_unmatched() !== 0) begin
      errors++;
      $display("FAIL sweep_zero: %0d unmatched responses, expected 0", count_unmatched());
    end
    checks++;
    if (nth_data(1, 5) !== 16'h0000) begin
      errors++;
      $display("FAIL sweep_addr5: got %h, expected 0000", nth_data(1, 5));
    end
  endtask

  task automatic test_store_load();
    int n;
    clear_queues();
    drive(1'b1, 1'b1, 5'h10, 16'h00A5);
    drive(1'b1, 1'b0, 5'h10, '0);
    n = edge_cnt + 1;
    idle(5);
    checks++;
    if (count_rl(1) !== 1 || nth_data(1, 0) !== 16'h00A5 || nth_edge(1, 0) !== n) begin
      errors++;
      $display("FAIL store_load_rl1: count=%0d data=%h edge=%0d, expected 1/00a5/%0d",
               count_rl(1), nth_data(1, 0), nth_edge(1, 0), n);
    end
    checks++;
    if (count_unmatched() !== 0) begin
      errors++;
      $display("FAIL store_load: %0d unmatched responses, expected 0", count_unmatched());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_queues();
    drive(1'b1, 1'b1, 5'd1, 16'h1111);
    drive(1'b1, 1'b1, 5'd2, 16'h2222);
    drive(1'b1, 1'b1, 5'd3, 16'h3333);
    drive(1'b1, 1'b0, 5'd3, '0);
    n = edge_cnt + 1;
    drive(1'b1, 1'b0, 5'd1, '0);
    drive(1'b1, 1'b0, 5'd2, '0);
    idle(6);
    checks++;
    if ({nth_data(3, 0), nth_data(3, 1), nth_data(3, 2)} !== {16'h3333, 16'h1111, 16'h2222}) begin
      errors++;
      $display("FAIL b2b_data_rl3: got %h %h %h, expected 3333 1111 2222",
               nth_data(3, 0), nth_data(3, 1), nth_data(3, 2));
    end
    checks++;
    if (count_rl(3) !== 3 || nth_edge(3, 0) !== n + 2 || nth_edge(3, 2) !== n + 4) begin
      errors++;
      $display("FAIL b2b_timing_rl3: count=%0d first=%0d last=%0d, expected 3/%0d/%0d",
               count_rl(3), nth_edge(3, 0), nth_edge(3, 2), n + 2, n + 4);
    end
    checks++;
    if (count_unmatched() !== 0) begin
      errors++;
      $display("FAIL b2b: %0d unmatched responses, expected 0", count_unmatched());
    end
  endtask

  task automatic test_load_then_store();
    clear_queues();
    drive(1'b1, 1'b1, 5'd7, 16'h003C);
    drive(1'b1, 1'b0, 5'd7, '0);
    drive(1'b1, 1'b1, 5'd7, 16'h00C3);
    drive(1'b1, 1'b0, 5'd7, '0);
    idle(5);
    checks++;
    if ({nth_data(2, 0), nth_data(2, 1)} !== {16'h003C, 16'h00C3}) begin
      errors++;
      $display("FAIL load_then_store_rl2: got %h %h, expected 003c 00c3", nth_data(2, 0), nth_data(2, 1));
    end
    checks++;
    if (count_unmatched() !== 0) begin
      errors++;
      $display("FAIL load_then_store: %0d unmatched responses, expected 0", count_unmatched());
    end
  endtask

  task automatic test_reset_inflight();
    clear_queues();
    drive(1'b1, 1'b1, 5'd9, 16'h1234);
    drive(1'b1, 1'b1, 5'd10, 16'h5678);
    drive(1'b1, 1'b0, 5'd9, '0);
    drive(1'b1, 1'b0, 5'd10, '0);
    apply_reset();
    wait_sweep();
    checks++;
    if (count_rl(3) !== 0 || count_rl(2) !== 0) begin
      errors++;
      $display("FAIL inflight_discard: rl3 pulses=%0d rl2 pulses=%0d, expected 0/0", count_rl(3), count_rl(2));
    end
    drive(1'b1, 1'b0, 5'd9, '0);
    drive(1'b1, 1'b0, 5'd10, '0);
    idle(5);
    checks++;
    if (count_rl(3) !== 2 || nth_data(3, 0) !== 16'h0000 || nth_data(3, 1) !== 16'h0000) begin
      errors++;
      $display("FAIL inflight_cleared: count=%0d data=%h %h, expected 2/0000/0000",
               count_rl(3), nth_data(3, 0), nth_data(3, 1));
    end
    checks++;
    if (count_unmatched() !== 0) begin
      errors++;
      $display("FAIL inflight: %0d unmatched responses, expected 0", count_unmatched());
    end
  endtask

  task automatic test_clear_ignores();
    clear_queues();
    drive(1'b1, 1'b1, 5'd2, 16'h4321);
    apply_reset();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 5'd2;
    req_wdata = 16'h00FF;
    wait_sweep();
    drive(1'b1, 1'b0, 5'd2, '0);
    idle(5);
    checks++;
    if (count_rl(1) !== 1 || nth_data(1, 0) !== 16'h0000) begin
      errors++;
      $display("FAIL clear_ignores: count=%0d data=%h, expected 1/0000", count_rl(1), nth_data(1, 0));
    end
    checks++;
    if (count_unmatched() !== 0) begin
      errors++;
      $display("FAIL clear_ignores_all: %0d unmatched responses, expected 0", count_unmatched());
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, AW'($urandom), DW'($urandom));
    idle(5);
    checks++;
    if (exp_q.size() !== obs_q.size() || count_unmatched() !== 0) begin
      errors++;
      $display("FAIL random: expected %0d responses, observed %0d, unmatched %0d",
               exp_q.size(), obs_q.size(), count_unmatched());
    end
    checks++;
    if (hold_err !== 0) begin
      errors++;
      $display("FAIL rdata_hold: %0d changes while idle, expected 0", hold_err);
    end
    checks++;
    if (nc_pulses !== 0 || nc_rdata !== '0) begin
      errors++;
      $display("FAIL noclear_idle: pulses=%0d rdata=%h, expected 0/0000", nc_pulses, nc_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_store_load();
    test_back_to_back();
    test_load_then_store();
    test_reset_inflight();
    test_clear_ignores();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
Parametrised successor to the generic 8-bit data memory. It has configurable data width and depth, and uses a valid/ready request port with a pipelined, fixed-latency read response. After reset it runs a hardware clear sweep so that memory contents start at zero. It sits between the processor's load/store stage and storage, and replaces the combinational-read memory wherever registered timing is required.

Parameters:
DW, 8, data word width in bits
AW, 8, address width; depth = 2**AW words
RL, 1, read latency in cycles, legal range 1..3
CLEAR_ON_RESET, 1, 1 = run a zeroing sweep after reset; 0 = go straight to READY with contents undefined

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  AW  word address
req_wdata  input  DW  store data
rsp_valid  output  1  load data valid, one-cycle pulse per load
rsp_rdata  output  DW  load data
busy  output  1  clear sweep in progress

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - reset is asynchronous and active-high.
  - Asserting reset immediately forces: rsp_valid=0, rsp_rdata=0, all latency-pipe valid bits=0, clear counter=0.
  - During reset, state = CLEAR if CLEAR_ON_RESET=1, else READY.
  - During reset, req_ready=0 and busy=CLEAR_ON_RESET.
  - Memory array is not reset by reset; only the sweep zeroes it.
- FSM states: CLEAR, READY.
- CLEAR:
  - busy=1, req_ready=0. req_valid is ignored; no write or read takes effect.
  - Each rising edge writes 0 to mem[cnt] and increments cnt.
  - After the edge that writes address 2**AW-1, go to READY. The sweep lasts exactly 2**AW cycles.
  - cnt is AW+1 bits wide and does not wrap.
- READY:
  - busy=0, req_ready=1. No other exit except reset.
  - A request is accepted on a rising edge where req_valid && req_ready.
- Store:
  - mem[req_addr] <= req_wdata on the acceptance edge.
  - No response is generated.
- Load:
  - The array is read using contents as of the acceptance edge. A store accepted on an earlier edge is visible.
  - Data enters a pipe of RL stages.
  - rsp_valid is high for exactly the one cycle following edge N+RL-1, where N is the acceptance edge. RL=1 means rsp_valid is high in the cycle immediately after acceptance.
- Throughput and ordering:
  - One request per cycle, loads and stores mixed freely.
  - Responses return in issue order.
  - There is no response backpressure; the consumer must always accept.
- rsp_rdata holds its last value while rsp_valid=0.
- Load followed on the next cycle by a store to the same address: the load returns the old value.
- Store followed on the next cycle by a load to the same address: the load returns the new value.
- Reset mid-operation (during the sweep or with loads in flight):
  - All in-flight responses are discarded; no rsp_valid pulse is emitted for them.
  - The sweep restarts from address 0 (when CLEAR_ON_RESET=1).
- Width rules:
  - req_addr uses all AW bits, so no access can be out of range.
  - Data is stored and returned at exactly DW bits; there is no extension or truncation.

Test Plan:
1. AW=4, CLEAR_ON_RESET=1: preload garbage via backdoor, pulse reset -> busy high for exactly 16 cycles; req_ready rises on cycle 17; load addr 5 -> rsp_rdata=0x00.
2. DW=8, RL=1: store 0xA5 to 0x10, load 0x10 on the next cycle -> rsp_valid pulses one cycle after load acceptance with rsp_rdata=0xA5.
3. RL=3, DW=16: stores 0x1111/0x2222/0x3333 to addrs 1/2/3, then back-to-back loads 3,1,2 -> three consecutive rsp_valid pulses starting 3 cycles after the first load: 0x3333, 0x1111, 0x2222.
4. RL=2: mem[7]=0x3C; load 7, then store 0xC3 to 7 on the next cycle -> response 0x3C; a later load 7 -> 0xC3.
5. RL=3: issue 2 loads, assert reset asynchronously mid-cycle one cycle later -> rsp_valid never pulses for either load; sweep restarts; after sweep, loads of those addresses -> 0.
6. During CLEAR, drive req_valid=1, req_write=1, addr 2, data 0xFF -> req_ready=0 throughout; after sweep, load 2 -> 0x00.
